csa_serial_sequencer: RTL and testbench

Multi-cycle wide adder. It reuses a single 4-bit carry-select slice over WIDTH/4 cycles to add two WIDTH-bit operands, least-significant nibble first. The slice carry-out is registered and fed back as the next slice's carry-in. The block sits between an operand producer and a result consumer, with a valid/ready handshake on each side, and runs one operation at a time with no overlap.

---
 rtl/csa_serial_sequencer_pkg.sv | 16 +
 rtl/csa_serial_sequencer_if.sv | 28 ++
 rtl/csa_serial_sequencer_csel_slice_4bit.sv | 32 +++
 rtl/csa_serial_sequencer.sv | 115 +++++++++++
 tb/tb_csa_serial_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/csa_serial_sequencer_pkg.sv
// Shared types and constants for the serial carry-select adder.
package csa_serial_sequencer_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/csa_serial_sequencer_if.sv
// Operand/result handshake bundle between producer, sequencer and consumer.
interface csa_serial_sequencer_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );

endinterface

// File: rtl/csa_serial_sequencer_csel_slice_4bit.sv
// Combinational 4-bit carry-select slice: both carry-in cases are rippled
// in parallel and the real carry-in picks one.
module csel_slice_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] s0;
  logic [3:0] s1;
  logic       c0;
  logic       c1;

  always_comb begin
    s0 = '0;
    s1 = '0;
    c0 = 1'b0;
    c1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0[i] = a[i] ^ b[i] ^ c0;
      c0    = (a[i] & b[i]) | (a[i] & c0) | (b[i] & c0);
      s1[i] = a[i] ^ b[i] ^ c1;
      c1    = (a[i] & b[i]) | (a[i] & c1) | (b[i] & c1);
    end
  end

  assign sum  = cin ? s1 : s0;
  assign cout = cin ? c1 : c0;

endmodule

// File: rtl/csa_serial_sequencer.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit carry-select slice,
// least-significant nibble first, with valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one slice per cycle, carry held in a register
// DONE  | result stable, out_valid high until out_ready
module csa_serial_sequencer
  import csa_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  csa_serial_sequencer_if.slave bus
);

  localparam int NSLICE = nslice(WIDTH);
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
    $error("csa_serial_sequencer: WIDTH must be a positive multiple of 4");
  end

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   sum_r;
  logic               c_out_r;
  logic               ovf_r;
  logic [SLICE_W-1:0] sl_a;
  logic [SLICE_W-1:0] sl_b;
  logic [SLICE_W-1:0] sl_sum;
  logic               sl_cout;
  logic               idx_last;

  assign sl_a     = op_a[int'(idx)*SLICE_W +: SLICE_W];
  assign sl_b     = op_b[int'(idx)*SLICE_W +: SLICE_W];
  assign idx_last = (idx == IDX_W'(NSLICE - 1));

  csel_slice_4bit u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (idx_last)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.busy      = (state != IDLE);
  end

  // Result bits of slices not yet reached keep their old value during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum_r   <= '0;
      c_out_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a  <= bus.a;
            op_b  <= bus.b;
            carry <= bus.c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_r[int'(idx)*SLICE_W +: SLICE_W] <= sl_sum;
          carry <= sl_cout;
          idx   <= idx + 1'b1;
          if (idx_last) begin
            c_out_r <= sl_cout;
            ovf_r   <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                       (sl_sum[SLICE_W-1] != op_a[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum   = sum_r;
  assign bus.c_out = c_out_r;
  assign bus.ovf   = ovf_r;

endmodule

// File: tb/tb_csa_serial_sequencer.sv
// Randomized self-checking bench for csa_serial_sequencer against an
// arithmetic reference model.
module tb_csa_serial_sequencer;

  localparam int W      = 16;
  localparam int NSLICE = W / 4;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   cyc;

  csa_serial_sequencer_if #(.WIDTH(W)) bus ();

  csa_serial_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: full-precision addition and the signed-overflow rule.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    s    = full[W-1:0];
    co   = full[W];
    ov   = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] s,
                              input logic co, input logic ov);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(bus.sum), 32'(s));
    chk({tag, "_cout"},  32'(bus.c_out), 32'(co));
    chk({tag, "_ovf"},   32'(bus.ovf), 32'(ov));
  endtask

  // Called at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic ci, input int hold);
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    int           cnt;
    model(a, b, ci, es, eco, eov);
    bus.a         = a;
    bus.b         = b;
    bus.c_in      = ci;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy_idle"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.a        = W'($urandom);
      bus.b        = W'($urandom);
      bus.c_in     = 1'($urandom);
      if (cnt == 0) begin
        chk({tag, "_rdy_run"},  32'(bus.in_ready), 32'd0);
        chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
      end
      if (bus.out_valid) break;
      @(posedge clk);
      cnt++;
    end
    chk({tag, "_latency"}, 32'(cnt), 32'(NSLICE));
    check_result(tag, es, eco, eov);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'($urandom);
      bus.a        = W'($urandom);
      chk({tag, "_rdy_done"}, 32'(bus.in_ready), 32'd0);
      check_result({tag, "_hold"}, es, eco, eov);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk({tag, "_rdy_after"},  32'(bus.in_ready), 32'd1);
    chk({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_sum_kept"},   32'(bus.sum), 32'(es));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
    int           acc_cyc [3];
    int           t;

    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy",      32'(bus.busy), 32'd0);
    chk("rst_sum",       32'(bus.sum), 32'd0);
    chk("rst_cout",      32'(bus.c_out), 32'd0);
    chk("rst_ovf",       32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("basic",   16'h1234, 16'h4321, 1'b0, 0);
    do_op("ripple",  16'hFFFF, 16'h0001, 1'b0, 1);
    do_op("ovf_pos", 16'h7FFF, 16'h0000, 1'b1, 0);
    do_op("ovf_neg", 16'h8000, 16'h8000, 1'b0, 2);
    do_op("bkpr",    16'h0F0F, 16'hF0F1, 1'b1, 3);

    // Reset in the middle of RUN.
    bus.a        = 16'hAAAA;
    bus.b        = 16'h5555;
    bus.c_in     = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_busy",      32'(bus.busy), 32'd0);
    chk("mrst_sum",       32'(bus.sum), 32'd0);
    chk("mrst_in_ready",  32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    // Back-to-back with both handshakes held high.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      t = 0;
      while (!bus.in_ready && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
      ra = W'($urandom);
      rb = W'($urandom);
      bus.a    = ra;
      bus.b    = rb;
      bus.c_in = 1'(i);
      model(ra, rb, 1'(i), es, eco, eov);
      @(posedge clk);
      acc_cyc[i] = cyc;
      t = 0;
      @(negedge clk);
      while (!bus.out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check_result("b2b", es, eco, eov);
      @(negedge clk);
    end
    chk("b2b_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'(NSLICE + 2));
    chk("b2b_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'(NSLICE + 2));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
